// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-stage PC sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    INT_ENTRY = 2'd2
  } pc_state_e;

  localparam int          PC_ADDR_W    = 32;
  localparam logic [31:0] PC_RESET_VEC = 32'h20;
  localparam logic [31:0] PC_INT_VEC   = 32'h10;
  localparam int          PC_INC       = 1;
  localparam int          PC_DEPTH     = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between Decode/Execute (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
  parameter int ADDR_W = pc_pkg::PC_ADDR_W
);
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic              rti;
  logic              int_req;
  logic              int_ack;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              in_handler;
  logic [ADDR_W-1:0] epc;
  logic              ovf_err;

  modport master (
    output stall, redirect, redirect_target, rti, int_req,
    input  int_ack, pc, pc_valid, in_handler, epc, ovf_err
  );

  modport slave (
    input  stall, redirect, redirect_target, rti, int_req,
    output int_ack, pc, pc_valid, in_handler, epc, ovf_err
  );
endinterface

// File: rtl/pc_save_stack.sv
// LIFO of saved return PCs for nested interrupts; top reads 0 when empty.
module pc_save_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           wr_idx, top_idx;

  assign wr_idx  = IW'(cnt_q);
  assign top_idx = IW'(cnt_q - CW'(1));
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign top     = empty ? '0 : mem_q[top_idx];

  // Push writes above the current top; pop just drops the count.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push && !full) begin
      mem_d[wr_idx] = din;
      cnt_d         = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Stack storage and depth counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: boot, increment, stall, redirect, interrupt entry/return.
// Optional macro PC_NEST_EN: nested interrupts through a DEPTH-entry saved-PC stack;
// without it a single EPC register masks nesting until rti.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = PC_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
  parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'(PC_INT_VEC),
  parameter int                INC       = PC_INC,
  parameter int                DEPTH     = PC_DEPTH
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);

  // A zero-entry stack is meaningless; reject it at elaboration.
  if (DEPTH < 1) begin : g_bad_depth
    $error("pc_sequencer: DEPTH must be at least 1");
  end

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] pc_inc, push_val, top_pc;
  logic              push, pop, ack, saved_any, accept_ok, nest_blocked;

  assign pc_inc   = pc_q + ADDR_W'(INC);
  // Return address follows a same-cycle branch so the handler resumes at the target.
  assign push_val = bus.redirect ? bus.redirect_target : pc_inc;

`ifdef PC_NEST_EN
  logic stk_empty, stk_full;

  pc_save_stack #(.W(ADDR_W), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_val),
    .top   (top_pc),
    .empty (stk_empty),
    .full  (stk_full)
  );

  assign saved_any    = !stk_empty;
  assign accept_ok    = !stk_full;
  assign nest_blocked = stk_full;
`else
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              hnd_q, hnd_d;

  // Single saved PC: loaded on accept, cleared on return.
  always_comb begin
    epc_d = epc_q;
    hnd_d = hnd_q;
    if (push) begin
      epc_d = push_val;
      hnd_d = 1'b1;
    end else if (pop) begin
      epc_d = '0;
      hnd_d = 1'b0;
    end
  end

  // EPC register and handler-active flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_q <= '0;
      hnd_q <= 1'b0;
    end else begin
      epc_q <= epc_d;
      hnd_q <= hnd_d;
    end
  end

  assign top_pc       = epc_q;
  assign saved_any    = hnd_q;
  assign accept_ok    = !hnd_q;
  assign nest_blocked = 1'b0;   // a masked request simply waits
`endif

  // Next-state and next-PC selection; rti > interrupt > redirect > stall > increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    pop     = 1'b0;
    ack     = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;              // pc stays on the reset vector this cycle
      RUN: begin
        if (bus.rti) begin
          if (saved_any) begin
            pc_d = top_pc;
            pop  = 1'b1;
          end else begin
            pc_d  = pc_inc;
            ovf_d = 1'b1;
          end
        end else if (bus.int_req && accept_ok && !bus.stall) begin
          push    = 1'b1;
          pc_d    = INT_VEC;
          ack     = 1'b1;
          state_d = INT_ENTRY;
        end else begin
          if (bus.int_req && nest_blocked) ovf_d = 1'b1;
          if (bus.redirect)    pc_d = bus.redirect_target;
          else if (!bus.stall) pc_d = pc_inc;
        end
      end
      INT_ENTRY: state_d = RUN;         // flush bubble: all control ignored
      default:   state_d = BOOT;
    endcase
  end

  // Sequencer state, PC and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.int_ack    = ack;
  assign bus.pc         = pc_q;
  assign bus.pc_valid   = (state_q != BOOT);
  assign bus.in_handler = saved_any;
  assign bus.epc        = saved_any ? top_pc : '0;
  assign bus.ovf_err    = ovf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + randomized bench for pc_sequencer (8-bit PC, 2-deep stack when nesting is built in).
module tb_pc_sequencer;
  localparam int AW    = 8;
  localparam int DEPTH = 2;
`ifdef PC_NEST_EN
  localparam int CAP  = DEPTH;
  localparam bit NEST = 1'b1;
`else
  localparam int CAP  = 1;
  localparam bit NEST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(AW)) bus ();

  pc_sequencer #(
    .ADDR_W(AW), .RESET_VEC(8'h20), .INT_VEC(8'h10), .INC(1), .DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int ntests = 0;
  int nfail  = 0;

  // Reference model: PC as an integer mod 256, saved PCs as a queue.
  int m_pc;
  bit m_boot, m_entry, m_ovf, m_ack;
  int m_saved[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 'h20; m_boot = 1; m_entry = 0; m_ovf = 0; m_ack = 0;
    m_saved.delete();
  endtask

  task automatic model_edge();
    m_ack = 0;
    if (m_boot) m_boot = 0;
    else if (m_entry) m_entry = 0;
    else if (bus.rti) begin
      if (m_saved.size() > 0) m_pc = m_saved.pop_back();
      else begin m_pc = (m_pc + 1) % 256; m_ovf = 1; end
    end else if (bus.int_req && m_saved.size() < CAP && !bus.stall) begin
      m_saved.push_back(bus.redirect ? int'(bus.redirect_target) : (m_pc + 1) % 256);
      m_pc = 'h10; m_entry = 1; m_ack = 1;
    end else begin
      if (NEST && bus.int_req && m_saved.size() == CAP) m_ovf = 1;
      if (bus.redirect)    m_pc = int'(bus.redirect_target);
      else if (!bus.stall) m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic check_all();
    chk("pc",         bus.pc,         m_pc);
    chk("pc_valid",   bus.pc_valid,   !m_boot);
    chk("in_handler", bus.in_handler, m_saved.size() > 0);
    chk("epc",        bus.epc,        (m_saved.size() > 0) ? m_saved[$] : 0);
    chk("ovf_err",    bus.ovf_err,    m_ovf);
  endtask

  task automatic drive(input bit s, input bit r, input logic [7:0] t, input bit ri, input bit ir);
    bus.stall = s; bus.redirect = r; bus.redirect_target = t; bus.rti = ri; bus.int_req = ir;
  endtask

  // One clock: check the combinational ack mid-cycle, then registered state after the edge.
  task automatic step();
    @(negedge clk);
    model_edge();
    chk("int_ack", bus.int_ack, m_ack);
    @(posedge clk);
    #1;
    check_all();
  endtask

  bit int_pend;

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_pc", bus.pc, 'h20);
    rst_n = 1'b1;

    // T1 boot
    step(); chk("t1_boot_pc", bus.pc, 'h20); chk("t1_valid", bus.pc_valid, 1);
    step(); chk("t1_pc21", bus.pc, 'h21);
    step(); chk("t1_pc22", bus.pc, 'h22);

    // T2 stall, then redirect overriding stall
    drive(1, 0, 8'h00, 0, 0);
    repeat (3) step();
    chk("t2_hold", bus.pc, 'h22);
    drive(1, 1, 8'h80, 0, 0);
    step(); chk("t2_redir", bus.pc, 'h80);

    // T3 interrupt entry and return
    drive(0, 1, 8'h30, 0, 0); step();
    drive(0, 0, 8'h00, 0, 1); step();
    chk("t3_epc", bus.epc, 'h31); chk("t3_vec", bus.pc, 'h10);
    drive(0, 0, 8'h00, 0, 0); step();
    chk("t3_bubble", bus.pc, 'h10);
    step(); chk("t3_h11", bus.pc, 'h11);
    drive(0, 0, 8'h00, 1, 0); step();
    chk("t3_rti_pc", bus.pc, 'h31); chk("t3_rti_hnd", bus.in_handler, 0);

    // T4 interrupt and redirect on the same edge
    drive(0, 1, 8'h40, 0, 0); step();
    drive(0, 1, 8'h90, 0, 1); step();
    chk("t4_epc", bus.epc, 'h90); chk("t4_vec", bus.pc, 'h10);
    drive(0, 0, 8'h00, 0, 0); step(); step();
    drive(0, 0, 8'h00, 1, 0); step();
    chk("t4_ret", bus.pc, 'h90);

    // T5 nesting / masking with a continuously held request
    drive(0, 0, 8'h00, 0, 1);
    repeat (6) step();
`ifdef PC_NEST_EN
    chk("t5_ovf", bus.ovf_err, 1);
`else
    chk("t5_masked_ovf", bus.ovf_err, 0);
`endif
    chk("t5_hnd", bus.in_handler, 1);
    drive(0, 0, 8'h00, 1, 1); step();   // rti wins over the pending request
    drive(0, 0, 8'h00, 0, 1); step();   // now accepted
    drive(0, 0, 8'h00, 0, 0); step(); step();
    drive(0, 0, 8'h00, 1, 0); step();
    drive(0, 0, 8'h00, 0, 0); step();

    // Reset while inside a handler
    drive(0, 0, 8'h00, 0, 1); step();
    drive(0, 0, 8'h00, 0, 0); step();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();
    step();

    // T6 wrap without flag, then rti underflow
    drive(0, 1, 8'hFF, 0, 0); step(); chk("t6_ff", bus.pc, 'hFF);
    drive(0, 0, 8'h00, 0, 0); step();
    chk("t6_wrap", bus.pc, 'h00); chk("t6_noflag", bus.ovf_err, 0);
    drive(0, 0, 8'h00, 1, 0); step();
    chk("t6_under", bus.ovf_err, 1); chk("t6_under_pc", bus.pc, 'h01);

    // Randomized traffic; a request is held until acknowledged
    int_pend = 0;
    for (int i = 0; i < 400; i++) begin
      if (!int_pend) int_pend = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 8'($urandom),
            $urandom_range(0, 7) == 0, int_pend);
      step();
      if (m_ack) int_pend = 0;
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
